// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide controller: default width,
// operation codes, sequencing states and iteration counter width.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned CNT_W    = 6;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational iteration step: shift-add multiply (div_mode=0) or
// restoring shift-subtract divide (div_mode=1) on a {acc_hi, acc_lo} pair.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] acc_hi_n,
    output logic [XLEN-1:0] acc_lo_n
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        // Multiply: acc_lo holds the remaining multiplier bits, acc_hi the partial product.
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        // Divide: acc_hi is the remainder (< divisor), acc_lo shifts dividend out and quotient in.
        rem_sh = {acc_hi, acc_lo[XLEN-1]};
        ge     = (rem_sh >= {1'b0, opb});
        diff   = rem_sh[XLEN-1:0] - opb;

        if (div_mode) begin
            acc_hi_n = ge ? diff : rem_sh[XLEN-1:0];
            acc_lo_n = {acc_lo[XLEN-2:0], ge};
        end else begin
            acc_hi_n = sum[XLEN:1];
            acc_lo_n = {sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for the multi-cycle multiply/divide unit.
// Optional single-cycle multiply: define MULDIV_FAST_MUL_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            rd_hi_req,
    input  logic            rd_lo_req,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_zero
);

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic            is_div_q, is_div_d;
    logic            dz_q, dz_d;
    logic            div_zero_q, div_zero_d;

    logic            signed_op;
    logic            op_known;
    logic [XLEN-1:0] rs_mag, rt_mag;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .div_mode (state_q == ST_DIV),
        .acc_hi   (acc_hi_q),
        .acc_lo   (acc_lo_q),
        .opb      (opb_q),
        .acc_hi_n (core_hi),
        .acc_lo_n (core_lo)
    );

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        op_known  = (op <= MD_MTLO);
        rs_mag    = (signed_op && rs_val[XLEN-1]) ? (~rs_val + 1'b1) : rs_val;
        rt_mag    = (signed_op && rt_val[XLEN-1]) ? (~rt_val + 1'b1) : rt_val;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, rs_mag} * {{XLEN{1'b0}}, rt_mag};
`endif
        prod_fix  = neg_lo_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        div_zero_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        MD_MULT, MD_MULTU: begin
                            acc_hi_d = '0;
                            acc_lo_d = rt_mag;
                            opb_d    = rs_mag;
                            neg_lo_d = signed_op && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                            cnt_d    = '0;
`ifdef MULDIV_FAST_MUL_EN
                            {acc_hi_d, acc_lo_d} = fast_prod;
                            state_d  = ST_FIX;
`else
                            state_d  = ST_MUL;
`endif
                        end
                        MD_DIV, MD_DIVU: begin
                            opb_d    = rt_mag;
                            neg_lo_d = signed_op && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                            neg_hi_d = signed_op && rs_val[XLEN-1];
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (rt_val == '0) begin
                                // Divide by zero bypasses iteration; FIX copies these through raw.
                                acc_hi_d = rs_val;
                                acc_lo_d = '1;
                                dz_d     = 1'b1;
                                state_d  = ST_FIX;
                            end else begin
                                acc_hi_d = '0;
                                acc_lo_d = rs_mag;
                                dz_d     = 1'b0;
                                state_d  = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                acc_hi_d = core_hi;
                acc_lo_d = core_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dz_q) begin
                    hi_d       = acc_hi_q;
                    lo_d       = acc_lo_q;
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = neg_hi_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                    lo_d = neg_lo_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign stall    = busy && ((op_valid && op_known) || rd_hi_req || rd_lo_req);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, randomized ops
// against an arithmetic reference model, stall and reset scenarios.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        rd_hi_req, rd_lo_req;
    logic        stall, busy, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_hi, ref_lo;
    logic        ref_dz;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .rd_hi_req (rd_hi_req),
        .rd_lo_req (rd_lo_req),
        .stall     (stall),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Architectural HI/LO result of one operation, from plain 64-bit arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp, sq, sr;
        longint unsigned up;
        ref_dz = 1'b0;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                ref_hi = sp[63:32]; ref_lo = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                ref_hi = up[63:32]; ref_lo = up[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    ref_hi = a; ref_lo = 32'hFFFF_FFFF; ref_dz = 1'b1;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    ref_hi = sr[31:0]; ref_lo = sq[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    ref_hi = a; ref_lo = 32'hFFFF_FFFF; ref_dz = 1'b1;
                end else begin
                    ref_hi = a % b; ref_lo = a / b;
                end
            end
            3'd4: ref_hi = a;
            3'd5: ref_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd0 || o == 3'd1) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (o == 3'd2 || o == 3'd3) return (b == 0) ? 1 : 33;
        return 0;
    endfunction

    task automatic issue_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        rd_hi_req = 1'b0; rd_lo_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", div_zero); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]  t_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] t_b  [6] = '{32'd3, 32'd3, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE};
        logic [31:0] t_lo [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'h1};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            issue_op(t_op[i], t_a[i], t_b[i]);
            wait_idle(cyc);
            checks++; if (cyc != exp_cycles(t_op[i], t_b[i])) begin errors++; $display("FAIL dir%0d_cycles got %0d exp %0d", i, cyc, exp_cycles(t_op[i], t_b[i])); end
            checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, t_hi[i]); end
            checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, t_lo[i]); end
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        issue_op(3'd3, 32'h1234, 32'd0);
        wait_idle(cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL dz_cycles got %0d exp 1", cyc); end
        checks++; if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_hilo got %h/%h exp 00001234/ffffffff", hi, lo); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse got %b exp 1", div_zero); end
        @(negedge clk);
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse_end got %b exp 0", div_zero); end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] a, b;
        int cyc;
        issue_op(3'd4, 32'h0BAD_F00D, '0);
        issue_op(3'd5, 32'h1357_9BDF, '0);
        ref_hi = 32'h0BAD_F00D; ref_lo = 32'h1357_9BDF;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 4) == 0) b = -b;
            model(o, a, b);
            issue_op(o, a, b);
            wait_idle(cyc);
            checks++; if (cyc != exp_cycles(o, b)) begin errors++; $display("FAIL rnd%0d_cycles op %0d got %0d exp %0d", i, o, cyc, exp_cycles(o, b)); end
            checks++; if (hi !== ref_hi) begin errors++; $display("FAIL rnd%0d_hi op %0d a %h b %h got %h exp %h", i, o, a, b, hi, ref_hi); end
            checks++; if (lo !== ref_lo) begin errors++; $display("FAIL rnd%0d_lo op %0d a %h b %h got %h exp %h", i, o, a, b, lo, ref_lo); end
            checks++; if (div_zero !== ref_dz) begin errors++; $display("FAIL rnd%0d_dz got %b exp %b", i, div_zero, ref_dz); end
        end
    endtask

    task automatic test_stall;
        int n;
        int bad;
        bit exp_busy;
        issue_op(3'd1, 32'd3, 32'd5);
`ifdef MULDIV_FAST_MUL_EN
        exp_busy = 1'b0;
`else
        exp_busy = 1'b1;
        repeat (4) @(negedge clk);
`endif
        rd_hi_req = 1'b1; op_valid = 1'b1; op = 3'd5; rs_val = 32'hCAFE_0001;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 60) begin
            #1;
            if (stall !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        checks++; if (bad != 0 || (n > 0) != exp_busy) begin errors++; $display("FAIL stall_busy got %0d bad of %0d cycles exp 0 bad", bad, n); end
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", stall); end
        checks++; if (lo !== 32'd15 || hi !== 32'd0) begin errors++; $display("FAIL stall_result got %h/%h exp 0/f", hi, lo); end
        @(negedge clk);
        op_valid = 1'b0; rd_hi_req = 1'b0;
        checks++; if (lo !== 32'hCAFE_0001 || busy !== 1'b0) begin errors++; $display("FAIL stall_mtlo got %h busy %b exp cafe0001 busy 0", lo, busy); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        issue_op(3'd2, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_state got busy %b %h/%h exp 0 0/0", busy, hi, lo); end
        @(negedge clk);
        checks++; if (div_zero !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got dz %b busy %b exp 0 0", div_zero, busy); end
        issue_op(3'd0, 32'd6, 32'd7);
        wait_idle(cyc);
        checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL rstmid_mult got %h/%h exp 0/2a", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
